// File: rtl/conv_ctrl_pkg.sv
// Shared types and geometry helpers for the convolution scan sequencer.
package conv_ctrl_pkg;

    typedef enum logic [2:0] {IDLE, RUN, DRAIN, WRITE, DONE} state_e;

    function automatic int out_w(input int img_w, input int k);
        return img_w - k + 1;
    endfunction

    function automatic int out_h(input int img_h, input int k);
        return img_h - k + 1;
    endfunction

    function automatic int taps(input int k);
        return k * k;
    endfunction

    // Counter width able to hold 0..n-1, never narrower than one bit.
    function automatic int cnt_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/conv_scan_ctrl_counter.sv
// Wrapping counter 0..VALMAX; fin flags the wrapping increment so counters chain.
module conv_scan_ctrl_counter #(
    parameter int VALMAX = 1,
    parameter int W      = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clear,
    input  logic         en,
    output logic [W-1:0] val,
    output logic         fin
);

    logic [W-1:0] val_q, val_d;
    logic         at_max;

    assign at_max = (val_q == W'(VALMAX));
    assign fin    = en && !clear && at_max;
    assign val    = val_q;

    always_comb begin
        val_d = val_q;
        if (clear)
            val_d = '0;
        else if (en)
            val_d = at_max ? '0 : val_q + W'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) val_q <= '0;
        else        val_q <= val_d;
    end

endmodule

// File: rtl/conv_scan_ctrl.sv
// Valid-mode KxK convolution scan: tap addresses, MAC strobes and per-pixel
// result write handshake for one pass over an IMG_H x IMG_W plane.
module conv_scan_ctrl
    import conv_ctrl_pkg::*;
#(
    parameter int IMG_W   = 28,
    parameter int IMG_H   = 28,
    parameter int K       = 5,
    parameter int ADDR_W  = 10,
    parameter int WADDR_W = 5
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               abort,
    input  logic               out_ready,
    output logic               busy,
    output logic               done,
    output logic [ADDR_W-1:0]  pix_addr,
    output logic [WADDR_W-1:0] w_addr,
    output logic               mac_en,
    output logic               mac_clr,
    output logic               out_valid,
    output logic [ADDR_W-1:0]  out_addr
);

    localparam int OUT_W = out_w(IMG_W, K);
    localparam int OUT_H = out_h(IMG_H, K);
    localparam int KW    = cnt_w(K);
    localparam int CW    = cnt_w(OUT_W);
    localparam int RW    = cnt_w(OUT_H);

    state_e        state_q;
    logic          busy_q, done_q, out_valid_q, mac_en_q, mac_clr_q;
    logic [KW-1:0] kc, kr;
    logic [CW-1:0] ocol;
    logic [RW-1:0] orow;
    logic          kc_fin, kr_fin, ocol_fin, orow_fin;
    logic          run, abort_hit, cnt_clr, wr_hs, first_tap, last_pix;

    assign run       = (state_q == RUN);
    assign abort_hit = abort && (state_q != IDLE);
    assign cnt_clr   = (state_q == IDLE) || abort_hit;
    assign wr_hs     = (state_q == WRITE) && out_ready;
    assign first_tap = (kc == '0) && (kr == '0);
    assign last_pix  = (ocol == CW'(OUT_W - 1)) && (orow == RW'(OUT_H - 1));

    // kc -> kr chain issues taps; ocol -> orow chain steps pixels on the write handshake.
    conv_scan_ctrl_counter #(.VALMAX(K - 1), .W(KW)) u_kc (
        .clk(clk), .rst_n(rst_n), .clear(cnt_clr), .en(run), .val(kc), .fin(kc_fin));
    conv_scan_ctrl_counter #(.VALMAX(K - 1), .W(KW)) u_kr (
        .clk(clk), .rst_n(rst_n), .clear(cnt_clr), .en(kc_fin), .val(kr), .fin(kr_fin));
    conv_scan_ctrl_counter #(.VALMAX(OUT_W - 1), .W(CW)) u_ocol (
        .clk(clk), .rst_n(rst_n), .clear(cnt_clr), .en(wr_hs), .val(ocol), .fin(ocol_fin));
    conv_scan_ctrl_counter #(.VALMAX(OUT_H - 1), .W(RW)) u_orow (
        .clk(clk), .rst_n(rst_n), .clear(cnt_clr), .en(ocol_fin), .val(orow), .fin(orow_fin));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            out_valid_q <= 1'b0;
            mac_en_q    <= 1'b0;
            mac_clr_q   <= 1'b0;
        end else begin
            mac_en_q  <= 1'b0;
            mac_clr_q <= 1'b0;
            done_q    <= 1'b0;
            if (abort_hit) begin
                state_q     <= IDLE;
                busy_q      <= 1'b0;
                out_valid_q <= 1'b0;
            end else begin
                case (state_q)
                    IDLE: if (start) begin
                        state_q <= RUN;
                        busy_q  <= 1'b1;
                    end
                    RUN: begin
                        // Strobes land with the read data one cycle later.
                        mac_en_q  <= 1'b1;
                        mac_clr_q <= first_tap;
                        if (kr_fin) state_q <= DRAIN;
                    end
                    DRAIN: begin
                        state_q     <= WRITE;
                        out_valid_q <= 1'b1;
                    end
                    WRITE: if (out_ready) begin
                        out_valid_q <= 1'b0;
                        if (last_pix) begin
                            state_q <= DONE;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= RUN;
                        end
                    end
                    DONE:    state_q <= IDLE;
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign out_valid = out_valid_q;
    assign mac_en    = mac_en_q;
    assign mac_clr   = mac_clr_q;

    assign pix_addr = run ? (ADDR_W'(orow) + ADDR_W'(kr)) * ADDR_W'(IMG_W)
                            + ADDR_W'(ocol) + ADDR_W'(kc)
                          : '0;
    assign w_addr   = run ? WADDR_W'(kr) * WADDR_W'(K) + WADDR_W'(kc) : '0;
    assign out_addr = ADDR_W'(orow) * ADDR_W'(OUT_W) + ADDR_W'(ocol);

    logic unused_fin;
    assign unused_fin = orow_fin;

endmodule
